// File: rtl/ecc_pkg.sv
// Shared types for the event capture counter: output FSM state encoding and
// the channel-index width helper.
package ecc_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } ecc_state_t;

   function automatic int ch_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ecc_channel.sv
// One counter channel: registered event enable, wrapping or saturating counter
// (ECC_SATURATE_EN), sticky overflow, and a single-entry capture slot.
module ecc_channel #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             evt,
   input  logic             gate,
   input  logic             clr,
   input  logic             ack,
   output logic [WIDTH-1:0] cap,
   output logic             pending,
   output logic             overflow
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic             evt_q;
   logic [WIDTH-1:0] cnt;
   logic             cap_hit;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         evt_q    <= 1'b0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         evt_q <= evt;
         if (clr) begin
            cnt      <= '0;
            overflow <= 1'b0;
         end else if (evt_q) begin
            if (cnt == CNT_MAX) begin
`ifdef ECC_SATURATE_EN
               cnt <= CNT_MAX;
`else
               cnt <= '0;
`endif
               overflow <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // A slot being handed off this cycle is free again, so it may be refilled now.
   assign cap_hit = gate & cnt[WIDTH-1] & (~pending | ack);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cap     <= '0;
         pending <= 1'b0;
      end else if (cap_hit) begin
         cap     <= cnt;
         pending <= 1'b1;
      end else if (ack) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/event_capture_counter.sv
// Multi-channel event counter with gated capture and a round-robin record
// output port. Counter behaviour at full scale selected by ECC_SATURATE_EN.
//
// state   | meaning
// IDLE    | no record presented, OUT_VALID low
// PRESENT | record on OUT_CH/OUT_DATA, OUT_VALID high until accepted
module event_capture_counter
   import ecc_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [CHANNELS-1:0]           EVT,
   input  logic [CHANNELS-1:0]           GATE,
   input  logic [CHANNELS-1:0]           CLR,
   output logic                          OUT_VALID,
   input  logic                          OUT_READY,
   output logic [ch_idx_w(CHANNELS)-1:0] OUT_CH,
   output logic [WIDTH-1:0]              OUT_DATA,
   output logic [CHANNELS-1:0]           OVERFLOW
);

   localparam int CW = ch_idx_w(CHANNELS);

   ecc_state_t          state;
   logic [CHANNELS-1:0] pending;
   logic [CHANNELS-1:0] ack;
   logic [CHANNELS-1:0] avail;
   logic [WIDTH-1:0]    cap [CHANNELS];
   logic [CW-1:0]       rr_ptr;
   logic [CW-1:0]       sel;
   logic [CW-1:0]       idx;
   logic [CW-1:0]       ptr_next;
   logic                sel_found;
   logic                hs;
   logic                grant;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      ecc_channel #(.WIDTH(WIDTH)) u_ch (
         .CLK      (CLK),
         .RST      (RST),
         .evt      (EVT[i]),
         .gate     (GATE[i]),
         .clr      (CLR[i]),
         .ack      (ack[i]),
         .cap      (cap[i]),
         .pending  (pending[i]),
         .overflow (OVERFLOW[i])
      );
   end

   assign hs = OUT_VALID & OUT_READY;

   always_comb begin
      ack = '0;
      if (hs) ack[OUT_CH] = 1'b1;
   end

   // The channel being accepted is excluded: a refill of its slot only lands next edge.
   assign avail = pending & ~ack;

   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      idx       = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         idx = CW'((int'(rr_ptr) + k) % CHANNELS);
         if (!sel_found && avail[idx]) begin
            sel       = idx;
            sel_found = 1'b1;
         end
      end
   end

   assign ptr_next = (sel == CW'(CHANNELS - 1)) ? '0 : sel + 1'b1;
   assign grant    = sel_found & ((state == IDLE) | hs);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         OUT_VALID <= 1'b0;
         OUT_CH    <= '0;
         OUT_DATA  <= '0;
         rr_ptr    <= '0;
      end else if (grant) begin
         state     <= PRESENT;
         OUT_VALID <= 1'b1;
         OUT_CH    <= sel;
         OUT_DATA  <= cap[sel];
         rr_ptr    <= ptr_next;
      end else if (state == PRESENT && hs) begin
         state     <= IDLE;
         OUT_VALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_event_capture_counter.sv
// Bench for event_capture_counter (WIDTH=8, CHANNELS=4): counter table plus
// capture/arbitration sequences checked against a record scoreboard.
module tb_event_capture_counter;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;

`ifdef ECC_SATURATE_EN
   localparam logic [7:0] CNT_256 = 8'hFF;
   localparam logic [7:0] CNT_257 = 8'hFF;
`else
   localparam logic [7:0] CNT_256 = 8'h00;
   localparam logic [7:0] CNT_257 = 8'h01;
`endif

   logic                CLK = 1'b0;
   logic                RST;
   logic [CHANNELS-1:0] EVT, GATE, CLR;
   logic                OUT_VALID, OUT_READY;
   logic [1:0]          OUT_CH;
   logic [WIDTH-1:0]    OUT_DATA;
   logic [CHANNELS-1:0] OVERFLOW;

   event_capture_counter #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .EVT       (EVT),
      .GATE      (GATE),
      .CLR       (CLR),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_CH    (OUT_CH),
      .OUT_DATA  (OUT_DATA),
      .OVERFLOW  (OVERFLOW)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         ch;
      int         n;
      logic [7:0] exp_cnt;
      logic       exp_ovf;
   } vec_t;

   typedef struct {
      logic [1:0] ch;
      logic [7:0] data;
   } rec_t;

   vec_t vecs [5];
   rec_t sb [$];
   rec_t r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] get_cnt(input int ch);
      case (ch)
         0:       return dut.g_ch[0].u_ch.cnt;
         1:       return dut.g_ch[1].u_ch.cnt;
         2:       return dut.g_ch[2].u_ch.cnt;
         default: return dut.g_ch[3].u_ch.cnt;
      endcase
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      sb.delete();
      cyc(3);
      RST = 1'b0;
   endtask

   // Record monitor: stability while stalled, and scoreboard pop on each acceptance.
   logic       pv = 1'b0, pr = 1'b0;
   logic [1:0] pch;
   logic [7:0] pdata;

   always @(negedge CLK) begin
      if (RST) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            chk("hold_valid", 32'(OUT_VALID), 32'd1);
            chk("hold_ch", 32'(OUT_CH), 32'(pch));
            chk("hold_data", 32'(OUT_DATA), 32'(pdata));
         end
         if (OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_record ch=%0d data=%0h required=none", OUT_CH, OUT_DATA);
            end else begin
               r = sb.pop_front();
               chk("rec_ch", 32'(OUT_CH), 32'(r.ch));
               chk("rec_data", 32'(OUT_DATA), 32'(r.data));
            end
         end
         pv    = OUT_VALID;
         pr    = OUT_READY;
         pch   = OUT_CH;
         pdata = OUT_DATA;
      end
   end

   initial begin
      vecs[0] = '{0,   5, 8'h05,   1'b0};
      vecs[1] = '{1, 256, CNT_256, 1'b1};
      vecs[2] = '{2,  16, 8'h10,   1'b0};
      vecs[3] = '{3, 255, 8'hFF,   1'b0};
      vecs[4] = '{0, 257, CNT_257, 1'b1};

      RST = 1'b1; EVT = '0; GATE = '0; CLR = '0; OUT_READY = 1'b0;
      cyc(2);
      chk("rst_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_ch", 32'(OUT_CH), 32'd0);
      chk("rst_data", 32'(OUT_DATA), 32'd0);
      chk("rst_ovf", 32'(OVERFLOW), 32'd0);
      chk("rst_cnt0", 32'(get_cnt(0)), 32'd0);
      RST = 1'b0;
      cyc(1);

      // Counter table: clear, count n events, check count and overflow.
      for (int v = 0; v < 5; v++) begin
         CLR[vecs[v].ch] = 1'b1; cyc(1); CLR = '0;
         EVT[vecs[v].ch] = 1'b1; cyc(vecs[v].n); EVT = '0;
         cyc(2);
         chk($sformatf("tbl%0d_cnt", v), 32'(get_cnt(vecs[v].ch)), 32'(vecs[v].exp_cnt));
         chk($sformatf("tbl%0d_ovf", v), 32'(OVERFLOW[vecs[v].ch]), 32'(vecs[v].exp_ovf));
      end
      chk("ovf_sticky", 32'(OVERFLOW), 32'h3);
      chk("no_rec_gate0", 32'(OUT_VALID), 32'd0);

      CLR[1] = 1'b1; cyc(1); CLR = '0;
      chk("clr1_cnt", 32'(get_cnt(1)), 32'd0);
      chk("clr1_ovf", 32'(OVERFLOW[1]), 32'd0);

      // Clear beats a simultaneous increment (ch2 at 0x10).
      EVT[2] = 1'b1; cyc(1);
      CLR[2] = 1'b1; EVT = '0; cyc(1);
      chk("clr_prio_cnt", 32'(get_cnt(2)), 32'd0);
      CLR = '0; cyc(1);
      chk("clr_prio_cnt2", 32'(get_cnt(2)), 32'd0);

      // Async reset while counting.
      EVT = 4'b0001; cyc(10);
      RST = 1'b1; #1;
      chk("arst_valid", 32'(OUT_VALID), 32'd0);
      chk("arst_ovf", 32'(OVERFLOW), 32'd0);
      chk("arst_cnt0", 32'(get_cnt(0)), 32'd0);
      cyc(3);
      EVT = '0; RST = 1'b0;
      cyc(3);
      chk("arst_cnt_after", 32'(get_cnt(0)), 32'd0);

      // Single capture on ch0 at 0x80.
      GATE = 4'b0001;
      EVT = 4'b0001; cyc(128); EVT = '0; cyc(2);
      chk("cap0_cnt", 32'(get_cnt(0)), 32'h80);
      sb.push_back('{2'd0, 8'h80});
      cyc(1);
      GATE = '0;
      cyc(1);
      chk("cap0_valid", 32'(OUT_VALID), 32'd1);
      chk("cap0_ch", 32'(OUT_CH), 32'd0);
      chk("cap0_data", 32'(OUT_DATA), 32'h80);
      OUT_READY = 1'b1; cyc(1); OUT_READY = 1'b0;
      chk("cap0_done", 32'(OUT_VALID), 32'd0);
      chk("cap0_sb_empty", 32'(sb.size()), 32'd0);

      // Three channels pending together, stalled then drained back-to-back.
      do_reset();
      EVT = 4'b1101; cyc(128); EVT = '0; cyc(2);
      GATE = 4'b1101; cyc(1); GATE = '0;
      sb.push_back('{2'd0, 8'h80});
      sb.push_back('{2'd2, 8'h80});
      sb.push_back('{2'd3, 8'h80});
      cyc(1);
      chk("rr_first_valid", 32'(OUT_VALID), 32'd1);
      chk("rr_first_ch", 32'(OUT_CH), 32'd0);
      cyc(4);
      chk("rr_stall_ch", 32'(OUT_CH), 32'd0);
      OUT_READY = 1'b1; cyc(3);
      chk("rr_drained", 32'(OUT_VALID), 32'd0);
      OUT_READY = 1'b0;
      chk("rr_sb_empty", 32'(sb.size()), 32'd0);

      // Refill on the handshake cycle of ch3 carries the newer count.
      EVT = 4'b1000; cyc(5); EVT = '0; cyc(2);
      GATE = 4'b1000; cyc(2);
      sb.push_back('{2'd3, 8'h85});
      chk("refill_ch", 32'(OUT_CH), 32'd3);
      chk("refill_data0", 32'(OUT_DATA), 32'h85);
      EVT = 4'b1000; cyc(3); EVT = '0; cyc(2);
      chk("refill_hold", 32'(OUT_DATA), 32'h85);
      sb.push_back('{2'd3, 8'h88});
      OUT_READY = 1'b1; cyc(1);
      GATE = '0;
      chk("refill_pending", 32'(dut.g_ch[3].u_ch.pending), 32'd1);
      chk("refill_gap", 32'(OUT_VALID), 32'd0);
      cyc(1);
      chk("refill_data1", 32'(OUT_DATA), 32'h88);
      cyc(1);
      OUT_READY = 1'b0;
      chk("refill_done", 32'(OUT_VALID), 32'd0);
      chk("refill_sb_empty", 32'(sb.size()), 32'd0);

      // Reset during a handshake drops the record for good.
      GATE = 4'b0010;
      EVT = 4'b0010; cyc(128); EVT = '0; cyc(4);
      GATE = '0;
      chk("mid_valid", 32'(OUT_VALID), 32'd1);
      chk("mid_ch", 32'(OUT_CH), 32'd1);
      OUT_READY = 1'b1;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         chk($sformatf("mid_norepresent%0d", k), 32'(OUT_VALID), 32'd0);
      end
      OUT_READY = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/event_capture_counter.md
EVENT_CAPTURE_COUNTER -- requirements
Module: event_capture_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter and capture width in bits (>=2).
REQ-002 Parameter CHANNELS, default 4, number of independent counter channels (>=1).
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 EVT  input  CHANNELS  per-channel count-enable event, level-sampled each cycle.
REQ-006 GATE  input  CHANNELS  per-channel capture qualifier.
REQ-007 CLR  input  CHANNELS  per-channel synchronous counter clear.
REQ-008 OUT_VALID  output  1  capture record available.
REQ-009 OUT_READY  input  1  consumer accepts record.
REQ-010 OUT_CH  output  max(1,clog2(CHANNELS))  channel index of presented record.
REQ-011 OUT_DATA  output  WIDTH  captured count of presented record.
REQ-012 OVERFLOW  output  CHANNELS  sticky per-channel overflow flag.

Function
REQ-013 EVT[i] SHALL be registered once (evt_q[i]); cnt[i] SHALL increment by 1 on the edge after evt_q[i] is high, i.e. 2-cycle EVT-to-count latency.
REQ-014 CLR[i] SHALL set cnt[i] to 0 and clear OVERFLOW[i] on the next edge, taking priority over a simultaneous increment.
REQ-015 Increment at cnt[i]=2^WIDTH-1 SHALL wrap cnt[i] to 0 and set OVERFLOW[i]; OVERFLOW[i] stays set until CLR[i] or RST.
REQ-016 Capture condition per channel: GATE[i] & cnt[i][WIDTH-1] & !pending[i], evaluated on current registered cnt; on true, cap[i]<=cnt[i], pending[i]<=1.
REQ-017 While pending[i] is set, further capture conditions on channel i SHALL be ignored (no overwrite).
REQ-018 Output FSM states IDLE and PRESENT; IDLE->PRESENT when any pending bit set; PRESENT->IDLE on OUT_VALID&OUT_READY when no other pending bit remains, else stays PRESENT with next record.
REQ-019 Selection SHALL be round-robin over pending bits, starting search at last-granted channel+1 (modulo CHANNELS), channel 0 first after reset.
REQ-020 OUT_VALID, OUT_CH, OUT_DATA SHALL be registered; earliest OUT_VALID is one edge after pending[i] sets.
REQ-021 While OUT_VALID&!OUT_READY, OUT_CH and OUT_DATA SHALL hold stable.
REQ-022 On handshake, pending[OUT_CH] SHALL clear; a capture condition on the same channel in that cycle SHALL re-set pending (set wins) with new cap value.
REQ-023 Back-to-back records SHALL be possible: sustained OUT_READY=1 yields one record per cycle while pending bits remain.
REQ-024 CLR[i] SHALL NOT clear pending[i] or cap[i].

Reset
REQ-025 RST high SHALL asynchronously force cnt, cap, evt_q, pending, OVERFLOW to 0, OUT_VALID=0, OUT_CH=0, OUT_DATA=0, FSM=IDLE, round-robin pointer to channel 0.
REQ-026 RST asserted mid-handshake SHALL discard the presented record; no record is re-presented after release.

Configuration
REQ-027 Macro ECC_SATURATE_EN defined: increment at 2^WIDTH-1 SHALL hold cnt at 2^WIDTH-1 and set OVERFLOW; undefined: wrap per REQ-015.

Structure
REQ-028 Shared package ecc_pkg SHALL hold FSM state typedef (IDLE, PRESENT) and the channel-index width function.
REQ-029 Per-channel counter, overflow and capture logic SHALL be sub-module ecc_channel, instantiated CHANNELS times; arbiter/FSM in top.

Verification (WIDTH=8, CHANNELS=4)
REQ-030 RST=1 for 3 cycles mid-count -> all outputs 0 immediately, cnt=0 after release.
REQ-031 EVT[0]=1 for 128 cycles, GATE[0]=1 -> cnt[0]=0x80, then OUT_VALID=1, OUT_CH=0, OUT_DATA=0x80.
REQ-032 EVT[1]=1 for 256 cycles, GATE=0 -> cnt[1]=0x00, OVERFLOW[1]=1; with ECC_SATURATE_EN cnt[1]=0xFF, OVERFLOW[1]=1; CLR[1] pulse -> cnt[1]=0, OVERFLOW[1]=0.
REQ-033 pending set on channels 0,2,3 same cycle, OUT_READY=0 for 5 cycles then 1 -> record ch0 held 5 cycles, then ch0,2,3 on consecutive cycles, OUT_VALID=0 after.
REQ-034 CLR[2] and evt_q[2] same cycle at cnt[2]=0x10 -> cnt[2]=0x00.
REQ-035 Handshake on ch3 while capture condition on ch3 true -> pending[3] remains 1, next ch3 record carries new count.
